cam_color_stat: RTL and testbench

- Per-frame colour analyser on the camera pixel clock, directly downstream of the camera capture stage.
- Taps the capture stage's frame-buffer write port (pixel write strobe plus RGB332 data) and the camera vsync, in parallel with the frame memory.
- Classifies every written pixel as red, green, blue or none, and counts each class over the frame.
- At frame end, publishes the dominant colour and the frame pixel count through a valid/ack handshake, for the control/display logic.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/px_classify.sv | 46 ++++
 rtl/cam_color_stat.sv | 188 ++++++++++++++++++
 tb/tb_cam_color_stat.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera colour statistics block:
// colour codes, FSM state encodings and RGB332 field positions.
package cam_pkg;

    typedef enum logic [1:0] {
        COL_NONE  = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_FLUSH1 = 3'd2,
        ST_FLUSH2 = 3'd3,
        ST_DECIDE = 3'd4
    } state_t;

    // RGB332 field positions
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/px_classify.sv
// Single-stage pixel classifier: RGB332 pixel -> red/green/blue/none.
// Ports: pclk, rst (async active-low), px_vld/px_data (accepted pixel),
//        cls_vld/cls (registered class, one cycle later).
module px_classify
    import cam_pkg::*;
#(
    parameter int unsigned MIN_LVL = 3
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       px_vld,
    input  logic [7:0] px_data,
    output logic       cls_vld,
    output color_t     cls
);

    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b3;
    color_t     cls_c;

    // Blue widened to 3 bits ({B, B[1]} -> 0,2,5,7); strict compares make any tie "none".
    always_comb begin
        r     = px_data[R_MSB:R_LSB];
        g     = px_data[G_MSB:G_LSB];
        b3    = {px_data[B_MSB:B_LSB], px_data[B_MSB]};
        cls_c = COL_NONE;
        if (r > g && r > b3 && 32'(r) >= MIN_LVL)
            cls_c = COL_RED;
        else if (g > r && g > b3 && 32'(g) >= MIN_LVL)
            cls_c = COL_GREEN;
        else if (b3 > r && b3 > g && 32'(b3) >= MIN_LVL)
            cls_c = COL_BLUE;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cls_vld <= 1'b0;
            cls     <= COL_NONE;
        end else begin
            cls_vld <= px_vld;
            cls     <= cls_c;
        end
    end

endmodule

// File: rtl/cam_color_stat.sv
// Per-frame colour analyser on the camera write port.
// Ports: pclk, rst (async active-low), vsync (high = blanking),
//        px_wr/mem_px_data (capture write strobe + RGB332 pixel),
//        res_ack (consumer ack), res_valid/color/px_count/win_count (result),
//        overrun (sticky lost-result flag), busy (ACCUM or FLUSH).
module cam_color_stat
    import cam_pkg::*;
#(
    parameter int unsigned AW      = 15,
    parameter int unsigned MIN_LVL = 3,
    parameter int unsigned FRAC_SH = 2
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          px_wr,
    input  logic [7:0]    mem_px_data,
    input  logic          res_ack,
    output logic          res_valid,
    output logic [1:0]    color,
    output logic [AW:0]   px_count,
    output logic [AW:0]   win_count,
    output logic          overrun,
    output logic          busy
);

    localparam int unsigned CW = AW + 1;

    state_t          state;
    state_t          state_nxt;
    logic            vsync_d;
    logic            px_wr_d;
    logic            armed;
    logic            vs_fall;
    logic            vs_rise;
    logic            accept_en;
    logic            cnt_clr;
    logic            decide;
    logic            accept;
    logic            cls_vld;
    color_t          cls;
    logic [CW-1:0]   px_cnt;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_g;
    logic [CW-1:0]   cnt_b;
    color_t          max_col;
    logic [CW-1:0]   max_cnt;
    logic [CW-1:0]   thr;
    color_t          dec_col;
    logic [CW-1:0]   dec_win;

    // Edge history; armed requires blanking to be seen after reset so a
    // frame already in progress at reset release is never measured.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vsync_d <= 1'b1;
            px_wr_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            px_wr_d <= px_wr;
            if (vsync)
                armed <= 1'b1;
        end
    end

    assign vs_fall = !vsync && vsync_d && armed;
    assign vs_rise = vsync && !vsync_d;
    assign accept  = accept_en && px_wr && !px_wr_d;

    // FSM state register; busy tracks the state being entered.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_ACCUM) || (state_nxt == ST_FLUSH1) ||
                     (state_nxt == ST_FLUSH2);
        end
    end

    // FSM next state and controls
    always_comb begin
        state_nxt = state;
        accept_en = 1'b0;
        cnt_clr   = 1'b0;
        decide    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (vs_fall)
                    state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                accept_en = 1'b1;
                if (vs_rise)
                    state_nxt = ST_FLUSH1;
            end
            ST_FLUSH1: state_nxt = ST_FLUSH2;
            ST_FLUSH2: state_nxt = ST_DECIDE;
            ST_DECIDE: begin
                decide    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    px_classify #(
        .MIN_LVL (MIN_LVL)
    ) u_classify (
        .pclk    (pclk),
        .rst     (rst),
        .px_vld  (accept),
        .px_data (mem_px_data),
        .cls_vld (cls_vld),
        .cls     (cls)
    );

    // Saturating per-frame counters
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            px_cnt <= '0;
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
        end else if (cnt_clr) begin
            px_cnt <= '0;
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
        end else if (cls_vld) begin
            if (px_cnt != '1)
                px_cnt <= px_cnt + CW'(1);
            if (cls == COL_RED && cnt_r != '1)
                cnt_r <= cnt_r + CW'(1);
            if (cls == COL_GREEN && cnt_g != '1)
                cnt_g <= cnt_g + CW'(1);
            if (cls == COL_BLUE && cnt_b != '1)
                cnt_b <= cnt_b + CW'(1);
        end
    end

    // Unique maximum that also covers the minimum fraction of the frame
    always_comb begin
        max_col = COL_NONE;
        max_cnt = '0;
        if (cnt_r > cnt_g && cnt_r > cnt_b) begin
            max_col = COL_RED;
            max_cnt = cnt_r;
        end else if (cnt_g > cnt_r && cnt_g > cnt_b) begin
            max_col = COL_GREEN;
            max_cnt = cnt_g;
        end else if (cnt_b > cnt_r && cnt_b > cnt_g) begin
            max_col = COL_BLUE;
            max_cnt = cnt_b;
        end
        thr     = px_cnt >> FRAC_SH;
        dec_col = COL_NONE;
        dec_win = '0;
        if (max_col != COL_NONE && max_cnt >= thr && max_cnt != '0) begin
            dec_col = max_col;
            dec_win = max_cnt;
        end
    end

    // Result register and valid/ack handshake; a new result wins over ack.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            color     <= 2'd0;
            px_count  <= '0;
            win_count <= '0;
            overrun   <= 1'b0;
        end else if (decide) begin
            color     <= dec_col;
            px_count  <= px_cnt;
            win_count <= dec_win;
            res_valid <= 1'b1;
            if (res_valid && !res_ack)
                overrun <= 1'b1;
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_color_stat.sv
// Directed bench for cam_color_stat: reset behaviour, vector table of frames,
// and hand-written handshake/overrun sequences.
module tb_cam_color_stat;

    localparam int unsigned AW = 15;

    logic          pclk;
    logic          rst;
    logic          vsync;
    logic          px_wr;
    logic [7:0]    mem_px_data;
    logic          res_ack;
    logic          res_valid;
    logic [1:0]    color;
    logic [AW:0]   px_count;
    logic [AW:0]   win_count;
    logic          overrun;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         na;
        logic [7:0] da;
        int         nb;
        logic [7:0] db;
        int         hold;
        int         ecol;
        int         epx;
        int         ewin;
    } vec_t;

    vec_t vecs [7];

    cam_color_stat #(
        .AW      (AW),
        .MIN_LVL (3),
        .FRAC_SH (2)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync       (vsync),
        .px_wr       (px_wr),
        .mem_px_data (mem_px_data),
        .res_ack     (res_ack),
        .res_valid   (res_valid),
        .color       (color),
        .px_count    (px_count),
        .win_count   (win_count),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_px(input logic [7:0] d, input int hold);
        px_wr       = 1'b1;
        mem_px_data = d;
        repeat (hold) tick();
        px_wr = 1'b0;
        tick();
    endtask

    // Ends in the cycle where vsync is raised (rise cycle N)
    task automatic send_frame(input vec_t v);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < v.na; i++) send_px(v.da, v.hold);
        for (int i = 0; i < v.nb; i++) send_px(v.db, v.hold);
        repeat (2) tick();
        vsync = 1'b1;
    endtask

    // From rise cycle N: result must be absent in N..N+3, present at N+4
    task automatic wait_result(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            chk({tag, "_valid_early"}, int'(res_valid), 0);
            chk({tag, "_busy"}, int'(busy), (k < 3) ? 1 : 0);
            tick();
        end
        @(negedge pclk);
        chk({tag, "_valid_n4"}, int'(res_valid), 1);
    endtask

    task automatic do_ack(input string tag);
        tick();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        @(negedge pclk);
        chk({tag, "_valid_after_ack"}, int'(res_valid), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_color"}, int'(color), 0);
        chk({tag, "_px_count"}, int'(px_count), 0);
        chk({tag, "_win_count"}, int'(win_count), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        vec_t fa;
        vec_t fb;

        vecs[0] = '{100, 8'hE0,  0, 8'h00, 1, 1, 100, 100};
        vecs[1] = '{ 60, 8'h1C, 40, 8'h03, 1, 2, 100,  60};
        vecs[2] = '{ 50, 8'h1C, 50, 8'h03, 1, 0, 100,   0};
        vecs[3] = '{ 10, 8'hE0, 90, 8'h00, 1, 0, 100,   0};
        vecs[4] = '{ 25, 8'hE0, 75, 8'h00, 1, 1, 100,  25};
        vecs[5] = '{ 16, 8'h03,  0, 8'h00, 3, 3,  16,  16};
        vecs[6] = '{  0, 8'h00,  0, 8'h00, 1, 0,   0,   0};

        rst         = 1'b0;
        vsync       = 1'b1;
        px_wr       = 1'b0;
        mem_px_data = 8'h00;
        res_ack     = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge pclk);
        chk_outputs_zero("reset");

        // Start a frame, then reset in the middle of it
        tick();
        rst = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) send_px(8'hE0, 1);
        @(negedge pclk);
        chk("accum_busy", int'(busy), 1);
        tick();
        rst = 1'b0;
        @(negedge pclk);
        chk_outputs_zero("midframe_reset");
        tick();
        rst = 1'b1;
        // Rest of the interrupted frame must not be measured
        for (int i = 0; i < 5; i++) send_px(8'hE0, 1);
        @(negedge pclk);
        chk("partial_busy", int'(busy), 0);
        repeat (2) tick();
        vsync = 1'b1;
        repeat (10) tick();
        @(negedge pclk);
        chk("partial_no_result", int'(res_valid), 0);
        chk("partial_idle", int'(busy), 0);

        // Vector table of full frames
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_frame(vecs[i]);
            wait_result(tag);
            chk({tag, "_color"}, int'(color), vecs[i].ecol);
            chk({tag, "_px_count"}, int'(px_count), vecs[i].epx);
            chk({tag, "_win_count"}, int'(win_count), vecs[i].ewin);
            chk({tag, "_overrun"}, int'(overrun), 0);
            do_ack(tag);
        end

        // Ack coinciding with DECIDE: new result loads, no overrun
        fa = '{5, 8'hE0, 0, 8'h00, 1, 1, 5, 5};
        fb = '{7, 8'h1C, 0, 8'h00, 1, 2, 7, 7};
        send_frame(fa);
        wait_result("same_a");
        chk("same_a_color", int'(color), 1);
        send_frame(fb);
        repeat (3) tick();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        @(negedge pclk);
        chk("same_valid", int'(res_valid), 1);
        chk("same_color", int'(color), 2);
        chk("same_px_count", int'(px_count), 7);
        chk("same_win_count", int'(win_count), 7);
        chk("same_overrun", int'(overrun), 0);
        do_ack("same");

        // Two results with no ack: second overwrites, overrun sticks
        fa = '{3, 8'hE0, 0, 8'h00, 1, 1, 3, 3};
        fb = '{9, 8'h03, 0, 8'h00, 1, 3, 9, 9};
        send_frame(fa);
        wait_result("ovr_a");
        chk("ovr_a_px_count", int'(px_count), 3);
        send_frame(fb);
        repeat (4) tick();
        @(negedge pclk);
        chk("ovr_valid", int'(res_valid), 1);
        chk("ovr_color", int'(color), 3);
        chk("ovr_px_count", int'(px_count), 9);
        chk("ovr_win_count", int'(win_count), 9);
        chk("ovr_overrun", int'(overrun), 1);
        do_ack("ovr");
        chk("ovr_sticky", int'(overrun), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
